bit_unpacker: RTL
=================

Name: bit_unpacker

Overview:
- Bit-stream extraction stage that feeds the 196-bit right barrel shifter datapath.
- Accumulates fixed-width input words LSB-first into a 196-bit bit buffer.
- Serves variable-length field requests (1..64 bits) by emitting the lowest `len` bits.
- Consumed bits are discarded by right-shifting the buffer by `len`, using a `barrel_shifter_right` instance (WIDTH=BUF_WIDTH, 7-bit amount).

Parameters:
- IN_WIDTH, 32: input word width in bits.
- BUF_WIDTH, 196: bit buffer capacity; must match the shifter WIDTH.
- OUT_MAX, 64: maximum field length per request; must be < 128.
- CNT_W, 8: width of the fill counter; must hold BUF_WIDTH.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_flush  in  1  synchronous clear of buffer and output stage.
- i_in_valid  in  1  input word valid.
- i_in_data  in  IN_WIDTH  input word; bit 0 is the oldest stream bit.
- o_in_ready  out  1  input word will be accepted this cycle.
- i_req_valid  in  1  field request valid.
- i_req_len  in  7  requested field length in bits.
- o_req_ready  out  1  request is accepted this cycle.
- o_out_valid  out  1  extracted field valid.
- o_out_data  out  OUT_MAX  extracted field, LSB-aligned, zero above len.
- o_out_len  out  7  length of the field in o_out_data.
- i_out_ready  in  1  downstream accepts o_out_data.
- o_level  out  CNT_W  current fill count (bits held in buffer).
- o_err  out  1  sticky flag: an illegal request length was presented.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - buffer=0, cnt=0, o_out_valid=0, o_out_data=0, o_out_len=0, o_err=0.
  - o_in_ready and o_req_ready are driven 0 while i_rst is high.
- Push:
  - o_in_ready = (cnt <= BUF_WIDTH-IN_WIDTH), i.e. cnt <= 164 at defaults.
  - This condition uses the registered cnt only; it has no combinational path from the pop side.
  - On i_in_valid && o_in_ready, the word is written at bit position cnt of the buffer, and cnt += IN_WIDTH.
- Pop:
  - Output stage free = !o_out_valid || i_out_ready.
  - o_req_ready = i_req_valid && (1 <= i_req_len <= OUT_MAX) && (i_req_len <= cnt) && free.
  - On accept, at the next edge:
    - o_out_valid=1.
    - o_out_data = buffer[len-1:0] zero-extended.
    - o_out_len = len.
    - buffer = shifter(buffer, len), with zero fill.
    - cnt -= len.
  - Latency: 1 cycle from accept to o_out_valid.
  - Back-to-back accepts every cycle are allowed when i_out_ready=1.
- Output hold:
  - While o_out_valid && !i_out_ready, o_out_data and o_out_len are held stable and no new request is accepted.
  - o_out_valid drops on the edge where i_out_ready=1 and no new accept occurs.
- Simultaneous push and pop in one cycle:
  - The shift is applied first, then the new word is inserted at position cnt-len.
  - cnt_next = cnt - len + IN_WIDTH.
- Illegal length:
  - i_req_valid with i_req_len==0 or i_req_len>OUT_MAX is never accepted.
  - It sets o_err=1; o_err is cleared only by reset or flush.
- Underflow: a request with len > cnt waits with o_req_ready=0 until enough bits arrive. It is not an error.
- Flush:
  - Same effect as reset on buffer, cnt, output stage and o_err.
  - Any push or pop in the same cycle is discarded.
  - Priority: i_rst > i_flush > push/pop.
- Reset or flush mid-operation drops all buffered and pending output data without emitting it.
- Buffer invariant: bits at position >= cnt are always 0.
- o_level is the registered cnt.

Test Plan:
- Basic extract:
  - Push 0x000000A5.
  - Request len 4, then len 4.
  - Expect outputs 0x5 then 0xA, o_out_len=4, o_level 32 -> 28 -> 24.
- Full stall:
  - Push 7 words back-to-back with no requests.
  - Expect words 1-6 accepted (o_level=192); o_in_ready=0 for the 7th.
  - After one len-32 pop, o_in_ready=1 again (cnt=160).
- Simultaneous push/pop:
  - With cnt=40, request len 12 while pushing 0xFFFFFFFF.
  - Expect cnt=60, and buffer bits [27:0] equal the remaining old bits.
  - Expect bits [59:28]=1s, and bits >= 60 are 0.
- Backpressure:
  - Hold i_out_ready=0 after a len-64 extract of an alternating 0x55555555 stream.
  - Expect o_out_data=0x5555555555555555 stable and o_req_ready=0 for 5 cycles.
  - Release: the next request is accepted the same cycle.
- Illegal/underflow:
  - Request len 65, expect o_err=1 and no accept.
  - Request len 10 with cnt=8, expect a wait, then accept one cycle after the next push.
- Flush/reset mid-stream:
  - With cnt=100 and o_out_valid=1, assert i_flush.
  - Expect o_level=0, o_out_valid=0, o_err=0 next cycle.
  - Repeat with i_rst and i_flush together; reset result.

Source files
------------

// File: rtl/bit_unpacker_if.sv
// rtl/bit_unpacker_if.sv - word-push, field-request and field-output handshakes of bit_unpacker
interface bit_unpacker_if #(
  parameter int IN_WIDTH = 32,
  parameter int OUT_MAX  = 64
);
  logic                i_in_valid;
  logic [IN_WIDTH-1:0] i_in_data;
  logic                o_in_ready;
  logic                i_req_valid;
  logic [6:0]          i_req_len;
  logic                o_req_ready;
  logic                o_out_valid;
  logic [OUT_MAX-1:0]  o_out_data;
  logic [6:0]          o_out_len;
  logic                i_out_ready;

  modport master (
    output i_in_valid, i_in_data, i_req_valid, i_req_len, i_out_ready,
    input  o_in_ready, o_req_ready, o_out_valid, o_out_data, o_out_len
  );

  modport slave (
    input  i_in_valid, i_in_data, i_req_valid, i_req_len, i_out_ready,
    output o_in_ready, o_req_ready, o_out_valid, o_out_data, o_out_len
  );
endinterface

// File: rtl/bit_unpacker.sv
// rtl/bit_unpacker.sv - LSB-first bit buffer serving variable-length field requests
module barrel_shifter_right #(
  parameter int WIDTH = 196,
  parameter int SHW   = 7
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   amt,
  output logic [WIDTH-1:0] result
);
  logic [WIDTH-1:0] stage [SHW+1];

  assign stage[0] = data;
  for (genvar s = 0; s < SHW; s++) begin : g_stage
    assign stage[s+1] = amt[s] ? (stage[s] >> (2 ** s)) : stage[s];
  end
  assign result = stage[SHW];
endmodule

module bit_unpacker #(
  parameter int IN_WIDTH  = 32,
  parameter int BUF_WIDTH = 196,
  parameter int OUT_MAX   = 64,
  parameter int CNT_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  bit_unpacker_if.slave    bus,
  output logic [CNT_W-1:0] o_level,
  output logic             o_err
);
  localparam logic [CNT_W-1:0] PUSH_LIMIT = CNT_W'(BUF_WIDTH - IN_WIDTH);

  logic [BUF_WIDTH-1:0] buffer, shifted, inserted;
  logic [CNT_W-1:0]     cnt, base, cnt_next;
  logic [OUT_MAX-1:0]   field, out_data;
  logic [6:0]           shamt, out_len;
  logic                 len_ok, free, pop, push, out_valid, err;

  assign len_ok = (bus.i_req_len != 7'd0) && (bus.i_req_len <= 7'(OUT_MAX));
  assign free   = !out_valid || bus.i_out_ready;

  // Push readiness looks only at the registered count, never at this cycle's pop.
  assign bus.o_in_ready  = !i_rst && (cnt <= PUSH_LIMIT);
  assign bus.o_req_ready = !i_rst && bus.i_req_valid && len_ok
                           && (CNT_W'(bus.i_req_len) <= cnt) && free;

  assign pop   = bus.o_req_ready;
  assign push  = bus.i_in_valid && bus.o_in_ready;
  assign shamt = pop ? bus.i_req_len : 7'd0;

  barrel_shifter_right #(.WIDTH(BUF_WIDTH), .SHW(7)) u_shift (
    .data   (buffer),
    .amt    (shamt),
    .result (shifted)
  );

  // New word lands just above the bits that survive this cycle's shift.
  assign base     = cnt - CNT_W'(shamt);
  assign inserted = shifted | (BUF_WIDTH'(bus.i_in_data) << base);
  assign cnt_next = base + (push ? CNT_W'(IN_WIDTH) : CNT_W'(0));
  assign field    = buffer[OUT_MAX-1:0] & ~({OUT_MAX{1'b1}} << bus.i_req_len);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      buffer    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_len   <= '0;
      err       <= 1'b0;
    end else begin
      buffer <= push ? inserted : shifted;
      cnt    <= cnt_next;
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= field;
        out_len   <= bus.i_req_len;
      end else if (bus.i_out_ready) begin
        out_valid <= 1'b0;
      end
      if (bus.i_req_valid && !len_ok) err <= 1'b1;
    end
  end

  assign bus.o_out_valid = out_valid;
  assign bus.o_out_data  = out_data;
  assign bus.o_out_len   = out_len;
  assign o_level         = cnt;
  assign o_err           = err;
endmodule
